branch_predictor: RTL and testbench

Dynamic branch predictor: a direct-mapped branch target buffer with 2-bit saturating counters. It sits between the execute stage and the fetch stage. It answers fetch-time lookups combinationally with a predicted direction and next PC. It trains on branch resolutions reported by the execute stage (isBranch, branchTaken, isBranchTakenPredicted, irregPc), and it is the producer of the isBranchTakenPredicted flag that travels down the pipeline.

---
 rtl/branch_predictor.sv | 171 +++++++++++++++++
 tb/tb_branch_predictor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
//
// Fetch asks for a prediction combinationally. Execute reports each resolved
// branch, and the table trains on those reports. Each entry holds valid, tag,
// target and a 2-bit counter. Only the valid vector and the statistics
// counters are reset.
//
// Ports
//   clk                       clock, all state updates on the rising edge
//   rst                       synchronous reset, active low
//   fetchPc                   PC being fetched this cycle
//   predictTaken              predicted direction for fetchPc
//   predictedNextPc           predicted next fetch PC
//   exIsBranch                single-cycle strobe: a branch resolved this cycle
//   exBranchTaken             resolved direction
//   exIsBranchTakenPredicted  prediction that travelled with the branch
//   exPc                      PC of the resolved branch
//   exIrregPc                 resolved target (only used when taken)
//   branchCount               resolved-branch count (stats build only, else 0)
//   missCount                 misprediction count (stats build only, else 0)
//
// Optional feature macro: BRANCH_PREDICTOR_STATS_EN
//   When it is defined, the branch and miss counters are built.
//   When it is not defined, both count outputs are tied to zero.
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int INDEX_WIDTH = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetchPc,
   output logic        predictTaken,
   output logic [31:0] predictedNextPc,
   input  logic        exIsBranch,
   input  logic        exBranchTaken,
   input  logic        exIsBranchTakenPredicted,
   input  logic [31:0] exPc,
   input  logic [31:0] exIrregPc,
   output logic [31:0] branchCount,
   output logic [31:0] missCount
);

   localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
   localparam int ENTRIES   = 1 << INDEX_WIDTH;

   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
   logic [31:0]          target_q [ENTRIES];
   logic [1:0]           ctr_q    [ENTRIES];

   // ---------------- lookup ----------------
   logic [INDEX_WIDTH-1:0] fetch_idx;
   logic [TAG_WIDTH-1:0]   fetch_tag;
   logic                   fetch_hit;

   assign fetch_idx = fetchPc[INDEX_WIDTH+1:2];
   assign fetch_tag = fetchPc[31:INDEX_WIDTH+2];
   assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

   // The lookup reads the registered entry only. A write in this same cycle
   // becomes visible one cycle later.
   // While reset is held, the prediction is forced to fall-through.
   assign predictTaken    = rst && fetch_hit && ctr_q[fetch_idx][1];
   assign predictedNextPc = predictTaken ? target_q[fetch_idx] : (fetchPc + 32'd4);

   // ---------------- training ----------------
   logic [INDEX_WIDTH-1:0] ex_idx;
   logic [TAG_WIDTH-1:0]   ex_tag;
   logic                   ex_hit;
   logic                   train_en;
   logic                   do_alloc;
   logic                   do_inc;
   logic                   do_dec;
   logic [1:0]             ctr_cur;
   logic [1:0]             ctr_d;

   assign ex_idx   = exPc[INDEX_WIDTH+1:2];
   assign ex_tag   = exPc[31:INDEX_WIDTH+2];
   assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign train_en = rst && exIsBranch;

   // A taken miss allocates. If another tag is resident at that index, it is
   // evicted.
   assign do_alloc = train_en &&  exBranchTaken && !ex_hit;
   assign do_inc   = train_en &&  exBranchTaken &&  ex_hit;
   assign do_dec   = train_en && !exBranchTaken &&  ex_hit;
   assign ctr_cur  = ctr_q[ex_idx];

   always_comb begin
      ctr_d = ctr_cur;
      if (do_alloc) begin
         ctr_d = 2'b10;
      end else if (do_inc) begin
         ctr_d = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
      end else if (do_dec) begin
         ctr_d = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (do_alloc) begin
         valid_d[ex_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // The payload fields are not reset. An entry with its valid bit clear is
   // never used, so its stale contents do no harm.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         tag_q[ex_idx] <= ex_tag;
      end
      if (do_alloc || do_inc) begin
         target_q[ex_idx] <= exIrregPc;
      end
      if (do_alloc || do_inc || do_dec) begin
         ctr_q[ex_idx] <= ctr_d;
      end
   end

   // ---------------- statistics ----------------
`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] miss_cnt_q,   miss_cnt_d;

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (exIsBranch) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
         if (exBranchTaken != exIsBranchTakenPredicted) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign branchCount = branch_cnt_q;
   assign missCount   = miss_cnt_q;

   logic unused_ok;
   assign unused_ok = ^exPc[1:0];
`else
   assign branchCount = 32'd0;
   assign missCount   = 32'd0;

   logic unused_ok;
   assign unused_ok = ^{exPc[1:0], exIsBranchTakenPredicted};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetchPc;
   logic        predictTaken;
   logic [31:0] predictedNextPc;
   logic        exIsBranch;
   logic        exBranchTaken;
   logic        exIsBranchTakenPredicted;
   logic [31:0] exPc;
   logic [31:0] exIrregPc;
   logic [31:0] branchCount;
   logic [31:0] missCount;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef BRANCH_PREDICTOR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   branch_predictor dut (
      .clk                      (clk),
      .rst                      (rst),
      .fetchPc                  (fetchPc),
      .predictTaken             (predictTaken),
      .predictedNextPc          (predictedNextPc),
      .exIsBranch               (exIsBranch),
      .exBranchTaken            (exBranchTaken),
      .exIsBranchTakenPredicted (exIsBranchTakenPredicted),
      .exPc                     (exPc),
      .exIrregPc                (exIrregPc),
      .branchCount              (branchCount),
      .missCount                (missCount)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One resolution edge. Inputs are set, the clock edge is taken, then the
   // strobe is dropped.
   task automatic train(input logic [31:0] pc, input logic taken,
                        input logic pred, input logic [31:0] tgt);
      exIsBranch = 1'b1; exPc = pc; exBranchTaken = taken;
      exIsBranchTakenPredicted = pred; exIrregPc = tgt;
      step();
      exIsBranch = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc);
      fetchPc = pc;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      fetchPc = 32'h100;
      exIsBranch = 1'b1; exBranchTaken = 1'b1; exIsBranchTakenPredicted = 1'b0;
      exPc = 32'h100; exIrregPc = 32'h80;
      step();
      step();
      exIsBranch = 1'b0;
      rst = 1'b1;
      look(32'h100);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h104}) begin
         n_fail++;
         $display("FAIL reset_lookup got %b/%h want 0/00000104", predictTaken, predictedNextPc);
      end
      n_checks++;
      if ({branchCount, missCount} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_counters got %0d/%0d want 0/0", branchCount, missCount);
      end
      look(32'hFFFF_FFFC);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL wrap_fallthrough got %b/%h want 0/00000000", predictTaken, predictedNextPc);
      end
   endtask

   task automatic test_train();
      train(32'h100, 1'b1, 1'b0, 32'h80);
      look(32'h100);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b1, 32'h80}) begin
         n_fail++;
         $display("FAIL train_alloc got %b/%h want 1/00000080", predictTaken, predictedNextPc);
      end
   endtask

   task automatic test_saturation();
      // ctr 10 -> 11 -> 11 (saturated) -> 10 after the not-taken update
      train(32'h100, 1'b1, 1'b1, 32'h80);
      train(32'h100, 1'b1, 1'b1, 32'h80);
      train(32'h100, 1'b0, 1'b1, 32'h0);
      look(32'h100);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b1, 32'h80}) begin
         n_fail++;
         $display("FAIL sat_high got %b/%h want 1/00000080", predictTaken, predictedNextPc);
      end
      // 10 -> 01 -> 00
      train(32'h100, 1'b0, 1'b1, 32'h0);
      train(32'h100, 1'b0, 1'b0, 32'h0);
      look(32'h100);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h104}) begin
         n_fail++;
         $display("FAIL sat_down got %b/%h want 0/00000104", predictTaken, predictedNextPc);
      end
      // The counter stays at 00. One taken update then gives 01, which is still
      // not-taken.
      train(32'h100, 1'b0, 1'b0, 32'h0);
      train(32'h100, 1'b1, 1'b0, 32'h80);
      look(32'h100);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h104}) begin
         n_fail++;
         $display("FAIL sat_low got %b/%h want 0/00000104", predictTaken, predictedNextPc);
      end
   endtask

   task automatic test_alias();
      train(32'h100, 1'b1, 1'b0, 32'h80);
      train(32'h100, 1'b1, 1'b0, 32'h80);
      train(32'h200, 1'b1, 1'b0, 32'h40);
      look(32'h200);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL alias_new got %b/%h want 1/00000040", predictTaken, predictedNextPc);
      end
      look(32'h100);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h104}) begin
         n_fail++;
         $display("FAIL alias_evicted got %b/%h want 0/00000104", predictTaken, predictedNextPc);
      end
      train(32'h300, 1'b0, 1'b0, 32'h999);
      look(32'h300);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h304}) begin
         n_fail++;
         $display("FAIL nt_no_alloc got %b/%h want 0/00000304", predictTaken, predictedNextPc);
      end
      look(32'h200);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL nt_keeps_resident got %b/%h want 1/00000040", predictTaken, predictedNextPc);
      end
   endtask

   task automatic test_collision();
      // 0x200 is resident and predicted taken, but holding reset masks it.
      rst = 1'b0;
      look(32'h200);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h204}) begin
         n_fail++;
         $display("FAIL reset_masks got %b/%h want 0/00000204", predictTaken, predictedNextPc);
      end
      step();
      rst = 1'b1;
      look(32'h200);
      n_checks++;
      if (predictTaken !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_clears got %b want 0", predictTaken);
      end
      fetchPc = 32'h100;
      exIsBranch = 1'b1; exPc = 32'h100; exBranchTaken = 1'b1;
      exIsBranchTakenPredicted = 1'b0; exIrregPc = 32'h80;
      #1;
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h104}) begin
         n_fail++;
         $display("FAIL collide_same got %b/%h want 0/00000104", predictTaken, predictedNextPc);
      end
      step();
      exIsBranch = 1'b0;
      #1;
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b1, 32'h80}) begin
         n_fail++;
         $display("FAIL collide_next got %b/%h want 1/00000080", predictTaken, predictedNextPc);
      end
   endtask

   task automatic test_stats();
      rst = 1'b0;
      step();
      rst = 1'b1;
      train(32'h500, 1'b1, 1'b1, 32'h20);
      train(32'h504, 1'b0, 1'b0, 32'h0);
      train(32'h508, 1'b1, 1'b0, 32'h30);
      #1;
      n_checks++;
      if (branchCount !== (STATS ? 32'd3 : 32'd0)) begin
         n_fail++;
         $display("FAIL stats_branch got %0d want %0d", branchCount, STATS ? 3 : 0);
      end
      n_checks++;
      if (missCount !== (STATS ? 32'd1 : 32'd0)) begin
         n_fail++;
         $display("FAIL stats_miss got %0d want %0d", missCount, STATS ? 1 : 0);
      end
      // A training strobe in the reset cycle is dropped, and it is not counted.
      rst = 1'b0;
      exIsBranch = 1'b1; exPc = 32'h600; exBranchTaken = 1'b1;
      exIsBranchTakenPredicted = 1'b0; exIrregPc = 32'h10;
      step();
      exIsBranch = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({branchCount, missCount} !== 64'd0) begin
         n_fail++;
         $display("FAIL stats_reset got %0d/%0d want 0/0", branchCount, missCount);
      end
      look(32'h500);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h504}) begin
         n_fail++;
         $display("FAIL reset_empty got %b/%h want 0/00000504", predictTaken, predictedNextPc);
      end
      look(32'h600);
      n_checks++;
      if ({predictTaken, predictedNextPc} !== {1'b0, 32'h604}) begin
         n_fail++;
         $display("FAIL reset_drop_train got %b/%h want 0/00000604", predictTaken, predictedNextPc);
      end
   endtask

   initial begin
      test_reset();
      test_train();
      test_saturation();
      test_alias();
      test_collision();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
